// File: rtl/map_pkg.sv
// Shared constants, state encoding and cell-slice helper for the card map controller.
package map_pkg;

  localparam int unsigned CELLS  = 144;
  localparam int unsigned CELL_W = 6;
  localparam int unsigned MAP_W  = CELLS * CELL_W;
  localparam int unsigned ADDR_W = 8;

  localparam logic [CELL_W-1:0] CARD_EMPTY = 6'd63;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // LSB position of cell idx inside the flat map bus
  function automatic int unsigned cell_lsb(input int unsigned idx);
    return idx * CELL_W;
  endfunction

endpackage

// File: rtl/map_update_ctrl_if.sv
// Write-request, bulk-op and map-output bundle between game/link logic and the map owner.
interface map_update_ctrl_if;
  import map_pkg::*;

  logic                req_l;
  logic [ADDR_W-1:0]   addr_l;
  logic [CELL_W-1:0]   data_l;
  logic                req_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [CELL_W-1:0]   data_r;
  logic                start_init;
  logic                start_shift;
  logic                gnt_l;
  logic                gnt_r;
  logic                addr_err;
  logic                busy;
  logic                op_done;
  logic                map_upd;
  logic [MAP_W-1:0]    map;

  modport master (
    output req_l, addr_l, data_l, req_r, addr_r, data_r, start_init, start_shift,
    input  gnt_l, gnt_r, addr_err, busy, op_done, map_upd, map
  );

  modport slave (
    input  req_l, addr_l, data_l, req_r, addr_r, data_r, start_init, start_shift,
    output gnt_l, gnt_r, addr_err, busy, op_done, map_upd, map
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; bit 0 = local, bit 1 = remote.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // 1: remote won the last tie, so local wins the next one
  logic r_rr_last;

  // Grant a lone requester directly; on a tie grant whoever did not win the last tie
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = r_rr_last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Fairness pointer only moves when both sides actually competed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_last <= 1'b1;
    end else if (en && (req == 2'b11)) begin
      r_rr_last <= gnt[1];
    end
  end

endmodule

// File: rtl/map_update_ctrl.sv
// Sole writer of the 144-cell card map: arbitrated single writes plus INIT/SHIFT bulk ops.
module map_update_ctrl
  import map_pkg::*;
(
  input logic              clk,
  input logic              rst,
  map_update_ctrl_if.slave bus
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_sweep_idx;
  logic                r_pend_init;
  logic                r_pend_shift;
  logic                r_busy;
  logic                r_op_done;
  logic                r_map_upd;
  logic [CELL_W-1:0]   r_cells [CELLS];

  logic                w_arb_en;
  logic [1:0]          w_gnt;
  logic                w_any_gnt;
  logic [ADDR_W-1:0]   w_addr;
  logic [CELL_W-1:0]   w_data;
  logic                w_addr_ok;
  logic                w_wr_single;
  logic                w_clr_init;
  logic                w_clr_shift;
  logic                w_init_last;
  logic                w_done_nxt;
  logic                w_upd_nxt;
  logic [MAP_W-1:0]    w_map;

  // Single writes are only arbitrated in IDLE with no bulk op waiting (and never in reset)
  assign w_arb_en = rst && (r_state == IDLE) && !r_pend_init && !r_pend_shift;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bus.req_r, bus.req_l}),
    .en  (w_arb_en),
    .gnt (w_gnt)
  );

  assign w_any_gnt   = |w_gnt;
  assign w_addr      = w_gnt[1] ? bus.addr_r : bus.addr_l;
  assign w_data      = w_gnt[1] ? bus.data_r : bus.data_l;
  assign w_addr_ok   = (w_addr < ADDR_W'(CELLS));
  assign w_wr_single = w_any_gnt && w_addr_ok;
  assign w_init_last = (r_sweep_idx == ADDR_W'(CELLS - 1));

  assign bus.gnt_l    = w_gnt[0];
  assign bus.gnt_r    = w_gnt[1];
  assign bus.addr_err = w_any_gnt && !w_addr_ok;
  assign bus.busy     = r_busy;
  assign bus.op_done  = r_op_done;
  assign bus.map_upd  = r_map_upd;
  assign bus.map      = w_map;

  // Next-state and pulse decode
  always_comb begin
    w_state_nxt = r_state;
    w_clr_init  = 1'b0;
    w_clr_shift = 1'b0;
    w_done_nxt  = 1'b0;
    w_upd_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pend_init) begin
          w_state_nxt = INIT;
          w_clr_init  = 1'b1;
        end else if (r_pend_shift) begin
          w_state_nxt = SHIFT;
          w_clr_shift = 1'b1;
        end else begin
          w_upd_nxt = w_wr_single;
        end
      end
      INIT: begin
        if (w_init_last) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
          w_upd_nxt   = 1'b1;
        end
      end
      SHIFT: begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
        w_upd_nxt   = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, pending flags and registered status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_pend_init  <= 1'b0;
      r_pend_shift <= 1'b0;
      r_busy       <= 1'b0;
      r_op_done    <= 1'b0;
      r_map_upd    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pend_init  <= w_clr_init  ? 1'b0 : (r_pend_init  || bus.start_init);
      r_pend_shift <= w_clr_shift ? 1'b0 : (r_pend_shift || bus.start_shift);
      r_busy       <= (w_state_nxt != IDLE);
      r_op_done    <= w_done_nxt;
      r_map_upd    <= w_upd_nxt;
    end
  end

  // INIT sweep pointer wraps to 0 on the last cell
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sweep_idx <= '0;
    end else if (r_state == INIT) begin
      r_sweep_idx <= w_init_last ? '0 : r_sweep_idx + ADDR_W'(1);
    end
  end

  // Map register bank: one INIT cell, a whole-map shift, or one arbitrated write per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < CELLS; i++) begin
        r_cells[i] <= CARD_EMPTY;
      end
    end else begin
      case (r_state)
        INIT: r_cells[r_sweep_idx] <= CARD_EMPTY;
        SHIFT: begin
          for (int unsigned i = 0; i < CELLS - 1; i++) begin
            r_cells[i] <= r_cells[i + 1];
          end
          r_cells[CELLS - 1] <= CARD_EMPTY;
        end
        default: begin
          if (w_wr_single) begin
            r_cells[w_addr] <= w_data;
          end
        end
      endcase
    end
  end

  // Flatten the bank onto the display bus
  always_comb begin
    w_map = '0;
    for (int unsigned i = 0; i < CELLS; i++) begin
      w_map[cell_lsb(i) +: CELL_W] = r_cells[i];
    end
  end

endmodule
